// File: rtl/dmux_14_pkg.sv
// dmux_14 shared constants and lane decode.
// Imported by the router top and its counters.
package dmux_14_pkg;

  localparam int LANES      = 4;
  localparam int SEL_W      = 2;
  localparam int DEF_DATA_W = 1;
  localparam int DEF_CNT_W  = 8;

  // One-hot lane decode; all-zero when routing is disabled.
  function automatic logic [LANES-1:0] lane_dec(
    input logic [SEL_W-1:0] sel,
    input logic             en
  );
    logic [LANES-1:0] d;
    d = '0;
    if (en) d[sel] = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/dmux_14_sat_counter.sv
// Saturating up-counter with increment enable.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_max;

  assign w_max = &r_cnt;
  assign cnt   = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (inc && !w_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmux_14.sv
// 1-to-4 registered demux with per-lane valid
// markers and saturating hit counters.
module dmux_14
  import dmux_14_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       din,
  input  logic [SEL_W-1:0]        A,
  input  logic                    en,
  output logic [LANES*DATA_W-1:0] Y,
  output logic [LANES-1:0]        y_vld,
  output logic [LANES*CNT_W-1:0]  hit_cnt
);

  logic [LANES-1:0]        w_dec;
  logic [LANES*DATA_W-1:0] r_y;
  logic [LANES-1:0]        r_vld;

  // Single decode feeds data lanes, markers and counters alike.
  assign w_dec = lane_dec(A, en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y   <= '0;
      r_vld <= '0;
    end else begin
      r_vld <= w_dec;
      for (int k = 0; k < LANES; k++) begin
        r_y[k*DATA_W +: DATA_W] <=
          w_dec[k] ? din : '0;
      end
    end
  end

  assign Y     = r_y;
  assign y_vld = r_vld;

  for (genvar k = 0; k < LANES; k++) begin : g_cnt
    sat_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk(clk),
      .rst(rst),
      .inc(w_dec[k]),
      .cnt(hit_cnt[k*CNT_W +: CNT_W])
    );
  end

  a_sel_known: assert property (
    @(posedge clk) disable iff (rst)
    en |-> !$isunknown(A)
  );

endmodule

// File: tb/tb_dmux_14.sv
// Directed bench for dmux_14 with an in-bench
// behavioural model checked on every falling edge.
module tb_dmux_14;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic [1:0]    A   = '0;
  logic          en  = 1'b0;
  logic [4*DW-1:0] Y;
  logic [3:0]      y_vld;
  logic [4*CW-1:0] hit_cnt;

  int total = 0;
  int bad   = 0;

  // Model state: lane values, marker, counts.
  logic [DW-1:0] m_y   [4] = '{default: '0};
  logic [3:0]    m_vld     = '0;
  int            m_cnt [4] = '{default: 0};

  dmux_14 #(
    .DATA_W(DW),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .A(A),
    .en(en),
    .Y(Y),
    .y_vld(y_vld),
    .hit_cnt(hit_cnt)
  );

  always #100 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_y[k]   <= '0;
        m_cnt[k] <= 0;
      end
      m_vld <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        m_y[k] <= (en && int'(A) == k) ? din : '0;
      end
      m_vld <= en ? (4'b0001 << A) : 4'b0000;
      if (en && m_cnt[A] < 255)
        m_cnt[A] <= m_cnt[A] + 1;
    end
  end

  function automatic logic [4*DW-1:0] pack_y();
    logic [4*DW-1:0] v;
    for (int k = 0; k < 4; k++) v[k*DW +: DW] = m_y[k];
    return v;
  endfunction

  function automatic logic [4*CW-1:0] pack_c();
    logic [4*CW-1:0] v;
    for (int k = 0; k < 4; k++) v[k*CW +: CW] = CW'(m_cnt[k]);
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_y",   Y,              pack_y());
    chk("model_vld", 32'(y_vld),     32'(m_vld));
    chk("model_cnt", hit_cnt,        pack_c());
  end

  task automatic drive(input logic e,
                       input logic [1:0] a,
                       input logic [DW-1:0] d);
    en  = e;
    A   = a;
    din = d;
    @(negedge clk);
  endtask

  initial begin
    #100000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_y",   Y,          32'h0);
    chk("rst_vld", 32'(y_vld), 32'h0);
    chk("rst_cnt", hit_cnt,    32'h0);
    rst = 1'b0;

    drive(1'b1, 2'd0, 8'h01);
    chk("first_y",   Y,          32'h0000_0001);
    chk("first_vld", 32'(y_vld), 32'h1);
    chk("first_cnt", hit_cnt,    32'h0000_0001);

    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 8'h01);
      chk("step_y",   Y,          32'h1 << (8*k));
      chk("step_vld", 32'(y_vld), 32'h1 << k);
    end
    chk("step_cnt", hit_cnt, 32'h0101_0102);

    drive(1'b0, 2'd2, 8'h01);
    chk("dis_y",   Y,          32'h0);
    chk("dis_vld", 32'(y_vld), 32'h0);
    chk("dis_cnt", hit_cnt,    32'h0101_0102);

    drive(1'b1, 2'd2, 8'h00);
    chk("zero_y",   Y,          32'h0);
    chk("zero_vld", 32'(y_vld), 32'h4);
    chk("zero_cnt", hit_cnt,    32'h0102_0102);

    drive(1'b1, 2'd1, 8'hA5);
    chk("wide_y",   Y,          32'h0000_A500);
    chk("wide_cnt", hit_cnt,    32'h0102_0202);

    repeat (300) drive(1'b1, 2'd3, 8'h77);
    chk("sat_y",   Y,       32'h7700_0000);
    chk("sat_cnt", hit_cnt, 32'hFF02_0202);

    rst = 1'b1;
    drive(1'b0, 2'd0, 8'h00);
    rst = 1'b0;
    repeat (5) drive(1'b1, 2'd3, 8'h01);
    chk("pre_y",   Y,       32'h0100_0000);
    chk("pre_cnt", hit_cnt, 32'h0500_0000);
    #20 rst = 1'b1;
    #1;
    chk("async_y",   Y,          32'h0);
    chk("async_vld", 32'(y_vld), 32'h0);
    chk("async_cnt", hit_cnt,    32'h0);
    @(negedge clk);
    rst = 1'b0;

    drive(1'b1, 2'd0, 8'h3C);
    chk("post_y",   Y,       32'h0000_003C);
    chk("post_cnt", hit_cnt, 32'h0000_0001);

    drive(1'b1, 2'd2, 8'hFF);
    drive(1'b0, 2'd1, 8'hFF);
    chk("tail_y", Y, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmux_14.md
DMUX_14 -- requirements
Module: dmux_14

Interface
REQ-001 Parameter DATA_W, default 1: width of the data input and of each output lane.
REQ-002 Parameter CNT_W, default 8: width of each per-lane saturating hit counter.
REQ-003 The block SHALL have exactly one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 din  input  DATA_W  data to route.
REQ-007 A  input  2  lane select; A[1] is the MSB; lane index = {A[1],A[0]}.
REQ-008 en  input  1  routing enable; 1 = route din, 0 = all lanes driven to zero.
REQ-009 Y  output  4*DATA_W  registered lanes; lane k occupies Y[k*DATA_W +: DATA_W].
REQ-010 y_vld  output  4  registered one-hot marker of the lane written in the last cycle.
REQ-011 hit_cnt  output  4*CNT_W  per-lane saturating counts; lane k occupies hit_cnt[k*CNT_W +: CNT_W].

Function
REQ-012 On each rising clk edge with en=1, lane A SHALL load din and every other lane SHALL load zero.
REQ-013 On each rising clk edge with en=0, all lanes of Y SHALL load zero.
REQ-014 Latency SHALL be exactly one clock from din/A/en sampling to Y; there is no combinational path from any input to any output.
REQ-015 y_vld SHALL load bit A set (one-hot) when en=1, and 4'b0000 when en=0.
REQ-016 y_vld SHALL be set independent of din value; din=0 with en=1 still flags the selected lane.
REQ-017 hit_cnt lane A SHALL increment by 1 on each clock edge where en=1; other lanes hold.
REQ-018 Each hit counter SHALL saturate at all-ones (2^CNT_W-1) and never wrap.
REQ-019 A change of A between clocks SHALL take effect at the next edge with no glitch lane; exactly one lane is non-zero-eligible per cycle.
REQ-020 A containing X/Z is unsupported; the implementation MAY output any value, but simulation assertions SHALL flag it.

Reset
REQ-021 While rst=1, Y SHALL be all zeros, y_vld 4'b0000, and all hit_cnt lanes zero, asynchronously, without waiting for clk.
REQ-022 Reset asserted mid-operation SHALL clear all state immediately; counters SHALL restart from zero.
REQ-023 The first edge after rst deasserts SHALL perform normal routing per REQ-012/013.

Structure
REQ-024 A shared package dmux_14_pkg SHALL hold the lane count constant (4), the select width (2), and default DATA_W/CNT_W.
REQ-025 A sub-module sat_counter (CNT_W-wide, increment enable, async active-high reset, saturate at max) SHALL be instantiated once per lane.
REQ-026 Lane decode SHALL be a single 2-to-4 one-hot decode shared by Y, y_vld and counter enables.

Verification
REQ-027 rst=1 then release; en=1, din=1, A=00 -> after 1 edge Y=4'b0001, y_vld=4'b0001, hit_cnt lane0=1.
REQ-028 din=1, en=1; A steps 00,01,10,11 on successive edges, 200 ns apart -> Y goes 0001, 0010, 0100, 1000 with one-cycle lag; only lane A non-zero at each step.
REQ-029 en=0, din=1, A=10 -> Y=0000, y_vld=0000, counters unchanged; en=1, din=0, A=10 -> Y=0000, y_vld=0100, lane2 count +1.
REQ-030 en=1, A=11 held for 300 edges, CNT_W=8 -> hit_cnt lane3 reaches 255 and stays 255; lanes 0-2 unchanged.
REQ-031 Assert rst between clock edges while Y=1000 and lane3 count=5 -> Y, y_vld, all counters read 0 before the next edge.
REQ-032 DATA_W=8, din=8'hA5, A=01 -> Y lane1 = 8'hA5, lanes 0/2/3 = 8'h00.
